// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_chk.sv
// Invariant monitor for the arbiter outputs; carries no functional logic.
module mux_rr_arbiter_chk
    import arb_pkg::*;
(
    input logic               clk,
    input logic               rst,
    input logic [NUM_REQ-1:0] grant,
    input logic [IDX_W-1:0]   S,
    input logic               en,
    input logic               preempt
);

    grant_onehot0_a: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(grant));

    en_matches_grant_a: assert property (@(posedge clk) disable iff (!rst)
        en == (|grant));

    sel_matches_grant_a: assert property (@(posedge clk) disable iff (!rst)
        en |-> (grant == idx_to_onehot(S)));

    preempt_needs_grant_a: assert property (@(posedge clk) disable iff (!rst)
        preempt |-> en);

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating first-set-bit search: lowest offset from ptr (mod NUM_REQ) wins.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        idx    = ptr;
        cand_s = ptr;
        valid  = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = ptr + IDX_W'(k);
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter driving the select/enable of a shared 4:1 N-bit mux,
// with optional hold-limit preemption when other requesters are waiting.
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   S,
    output logic               en,
    output logic               preempt
);

    localparam int               CNT_W       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit               PREEMPT_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_MAX_C  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST_C = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b0}};

    arb_state_t         state_r, state_s;
    logic [NUM_REQ-1:0] grant_r, grant_s;
    logic [IDX_W-1:0]   s_r, s_s;
    logic               en_r, en_s;
    logic               preempt_r, preempt_s;
    logic [IDX_W-1:0]   ptr_r, ptr_s;
    logic [CNT_W-1:0]   hold_cnt_r, hold_cnt_s;

    logic [NUM_REQ-1:0] others_s;
    logic               release_s;
    logic               hold_exp_s;
    logic [NUM_REQ-1:0] pick_req_s;
    logic [IDX_W-1:0]   pick_ptr_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_valid_s;

    // Owner status: whether it let go, and whether its hold budget is spent while others wait.
    always_comb begin
        others_s   = req & ~idx_to_onehot(s_r);
        release_s  = ~req[s_r];
        hold_exp_s = PREEMPT_EN && (hold_cnt_r >= HOLD_LAST_C) && (|others_s);
    end

    // One picker shared by both states: full req from ptr when idle, competitors after the owner otherwise.
    always_comb begin
        pick_req_s = req;
        pick_ptr_s = ptr_r;
        if (state_r == OWN) begin
            pick_req_s = others_s;
            pick_ptr_s = s_r + IDX_W'(1);
        end else begin
            pick_req_s = req;
            pick_ptr_s = ptr_r;
        end
    end

    rr_pick u_rr_pick (
        .req   (pick_req_s),
        .ptr   (pick_ptr_s),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        s_s        = s_r;
        en_s       = en_r;
        preempt_s  = 1'b0;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s    = OWN;
                    grant_s    = idx_to_onehot(pick_idx_s);
                    s_s        = pick_idx_s;
                    en_s       = 1'b1;
                    hold_cnt_s = {CNT_W{1'b0}};
                end else begin
                    grant_s = {NUM_REQ{1'b0}};
                    en_s    = 1'b0;
                end
            end
            OWN: begin
                if (release_s || hold_exp_s) begin
                    // The outgoing owner moves to the back of the rotation either way.
                    ptr_s      = s_r + IDX_W'(1);
                    hold_cnt_s = {CNT_W{1'b0}};
                    if (pick_valid_s) begin
                        grant_s   = idx_to_onehot(pick_idx_s);
                        s_s       = pick_idx_s;
                        en_s      = 1'b1;
                        preempt_s = ~release_s;
                    end else begin
                        state_s = IDLE;
                        grant_s = {NUM_REQ{1'b0}};
                        en_s    = 1'b0;
                    end
                end else begin
                    hold_cnt_s = (hold_cnt_r >= HOLD_MAX_C) ? hold_cnt_r : hold_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                grant_s    = {NUM_REQ{1'b0}};
                en_s       = 1'b0;
                hold_cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            grant_r    <= {NUM_REQ{1'b0}};
            s_r        <= {IDX_W{1'b0}};
            en_r       <= 1'b0;
            preempt_r  <= 1'b0;
            ptr_r      <= {IDX_W{1'b0}};
            hold_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            s_r        <= s_s;
            en_r       <= en_s;
            preempt_r  <= preempt_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    assign grant   = grant_r;
    assign S       = s_r;
    assign en      = en_r;
    assign preempt = preempt_r;

    mux_rr_arbiter_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .grant   (grant_r),
        .S       (s_r),
        .en      (en_r),
        .preempt (preempt_r)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios with literal expectations, then random
// request traffic against an owner/rotation model, on a MAX_HOLD=8 and a MAX_HOLD=0 instance.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] grant_w [2];
    logic [1:0] s_w     [2];
    logic       en_w    [2];
    logic       pre_w   [2];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.MAX_HOLD(8)) dut_hold8 (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant_w[0]), .S(s_w[0]), .en(en_w[0]), .preempt(pre_w[0])
    );

    mux_rr_arbiter #(.MAX_HOLD(0)) dut_nohold (
        .clk(clk), .rst(rst), .req(req),
        .grant(grant_w[1]), .S(s_w[1]), .en(en_w[1]), .preempt(pre_w[1])
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // Model: current owner (-1 = none), rotation start, cycles owned so far, last select, preempt flag.
    int lim     [2] = '{8, 0};
    int m_owner [2];
    int m_ptr   [2];
    int m_owned [2];
    int m_s     [2];
    bit m_pre   [2];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_owned[k] = 0;
            m_s[k]     = 0;
            m_pre[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input logic [3:0] r);
        for (int k = 0; k < 2; k++) begin
            int         o;
            int         p;
            logic [3:0] others;
            bit         rel;
            bit         expired;
            m_pre[k] = 1'b0;
            if (m_owner[k] < 0) begin
                p = pick(r, m_ptr[k]);
                if (p >= 0) begin
                    m_owner[k] = p;
                    m_s[k]     = p;
                    m_owned[k] = 1;
                end
            end else begin
                o       = m_owner[k];
                others  = r & ~(4'b0001 << o);
                rel     = !r[o];
                expired = (lim[k] != 0) && (m_owned[k] >= lim[k]) && (others != 4'b0000);
                if (rel || expired) begin
                    m_ptr[k] = (o + 1) % 4;
                    p = pick(others, m_ptr[k]);
                    if (p >= 0) begin
                        m_owner[k] = p;
                        m_s[k]     = p;
                        m_owned[k] = 1;
                        m_pre[k]   = !rel;
                    end else begin
                        m_owner[k] = -1;
                    end
                end else begin
                    m_owned[k]++;
                end
            end
        end
    endtask

    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        if (!rst) model_reset();
        else model_step(r);
        #1;
    endtask

    task automatic expect0(input string name, input logic [3:0] g, input logic [1:0] s,
                           input logic e, input logic p);
        check({name, ".grant"},   grant_w[0],        g);
        check({name, ".S"},       {2'b00, s_w[0]},   {2'b00, s});
        check({name, ".en"},      {3'b000, en_w[0]}, {3'b000, e});
        check({name, ".preempt"}, {3'b000, pre_w[0]}, {3'b000, p});
    endtask

    // Every cycle, compare both instances against the model.
    always @(negedge clk) begin : cmp
        logic [3:0] eg;
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                eg = (m_owner[k] < 0) ? 4'b0000 : (4'b0001 << m_owner[k]);
                check($sformatf("model.grant[%0d]", k), grant_w[k], eg);
                check($sformatf("model.S[%0d]", k), {2'b00, s_w[k]}, 4'(m_s[k]));
                check($sformatf("model.en[%0d]", k), {3'b000, en_w[k]}, {3'b000, m_owner[k] >= 0});
                check($sformatf("model.preempt[%0d]", k), {3'b000, pre_w[k]}, {3'b000, m_pre[k]});
            end
        end
    end

    initial begin
        logic [3:0] rcur;

        // Reset with everyone requesting: nothing granted.
        rst = 1'b0;
        req = 4'b1111;
        model_reset();
        #3;
        expect0("rst_async", 4'b0000, 2'b00, 1'b0, 1'b0);
        chk_on = 1'b1;
        tick(4'b1111);
        expect0("rst_held", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(4'b0000);
            expect0("idle", 4'b0000, 2'b00, 1'b0, 1'b0);
        end

        // Single request: one-cycle latency, S kept after release.
        tick(4'b0100);
        expect0("single_grant", 4'b0100, 2'b10, 1'b1, 1'b0);
        tick(4'b0000);
        expect0("single_release", 4'b0000, 2'b10, 1'b0, 1'b0);

        // Fresh reset, then fairness with each owner dropping after two cycles.
        #2 rst = 1'b0;
        model_reset();
        tick(4'b0000);
        rst = 1'b1;
        tick(4'b1111);
        expect0("rr_0", 4'b0001, 2'b00, 1'b1, 1'b0);
        tick(4'b1111);
        tick(4'b1110);
        expect0("rr_1", 4'b0010, 2'b01, 1'b1, 1'b0);
        tick(4'b1111);
        tick(4'b1101);
        expect0("rr_2", 4'b0100, 2'b10, 1'b1, 1'b0);
        tick(4'b1111);
        tick(4'b1011);
        expect0("rr_3", 4'b1000, 2'b11, 1'b1, 1'b0);
        tick(4'b1111);
        tick(4'b0111);
        expect0("rr_wrap", 4'b0001, 2'b00, 1'b1, 1'b0);

        // Preemption after eight owned cycles with a competitor waiting.
        tick(4'b0000);
        tick(4'b0010);
        expect0("pre_own", 4'b0010, 2'b01, 1'b1, 1'b0);
        tick(4'b0010);
        for (int i = 0; i < 6; i++) begin
            tick(4'b1010);
            expect0("pre_wait", 4'b0010, 2'b01, 1'b1, 1'b0);
        end
        tick(4'b1010);
        expect0("pre_switch", 4'b1000, 2'b11, 1'b1, 1'b1);
        tick(4'b1010);
        expect0("pre_pulse_end", 4'b1000, 2'b11, 1'b1, 1'b0);
        tick(4'b0010);
        expect0("pre_regain", 4'b0010, 2'b01, 1'b1, 1'b0);

        // Sole owner is never preempted; a late competitor wins immediately.
        tick(4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick(4'b0001);
            expect0("sole", 4'b0001, 2'b00, 1'b1, 1'b0);
        end
        tick(4'b0101);
        expect0("sole_late", 4'b0100, 2'b10, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a grant.
        tick(4'b0000);
        tick(4'b0010);
        expect0("mid_grant", 4'b0010, 2'b01, 1'b1, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        expect0("mid_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick(4'b1111);
        rst = 1'b1;
        tick(4'b1111);
        expect0("after_reset", 4'b0001, 2'b00, 1'b1, 1'b0);

        // Random traffic: sticky requests so hold limits are reached, rare mid-cycle resets.
        rcur = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(7))
                0: rcur = 4'($urandom_range(15));
                1: rcur[$urandom_range(3)] = ~rcur[$urandom_range(3)];
                default: rcur = rcur;
            endcase
            if ($urandom_range(199) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                tick(rcur);
                rst = 1'b1;
            end else begin
                tick(rcur);
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
